// File: rtl/load_store_unit_pkg.sv
// Isa package: access sizes, LSU states and memory geometry.
// Shared by the load/store unit and its lane aligner.
package Isa;

    localparam int MEMORY_DATA_WIDTH = 32;
    localparam int MEMORY_DEPTH      = 256;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALF     = 2'd1,
        WORD     = 2'd2,
        RESERVED = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RESPOND = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ram_port.sv
// RamPort: single-port data RAM bundle.
// read_data is combinational from address; writes commit on the clock edge.
interface RamPort #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 8
) ();

    logic                 enable;
    logic                 write_enable;
    logic [AddrWidth-1:0] address;
    logic [DataWidth-1:0] write_data;
    logic [DataWidth-1:0] read_data;

    modport Controller (
        output enable,
        output write_enable,
        output address,
        output write_data,
        input  read_data
    );

    modport Memory (
        input  enable,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data
    );

endinterface

// File: rtl/load_store_unit_aligner.sv
// byte_lane_aligner: combinational lane extract/extend for loads
// and lane merge for read-modify-write stores (little-endian lanes).
module byte_lane_aligner
    import Isa::*;
#(
    parameter int DataWidth   = 32,
    parameter int OffsetWidth = 2
) (
    input  access_size_t           size,
    input  logic                   is_unsigned,
    input  logic [OffsetWidth-1:0] offset,
    input  logic [DataWidth-1:0]   load_word,
    input  logic [DataWidth-1:0]   merge_word,
    input  logic [DataWidth-1:0]   store_data,
    output logic [DataWidth-1:0]   load_data,
    output logic [DataWidth-1:0]   merged_word
);

    logic [OffsetWidth+2:0] shift;
    logic [DataWidth-1:0]   shifted;
    logic [DataWidth-1:0]   lane_mask;
    logic [DataWidth-1:0]   placed_mask;
    logic                   sign_bit;

    // Shift the addressed lane down, mask it, extend; and place store bytes.
    always_comb begin
        shift       = {offset, 3'b000};
        shifted     = load_word >> shift;
        lane_mask   = DataWidth'(32'hFFFF_FFFF);
        sign_bit    = shifted[31];
        unique case (size)
            BYTE: begin
                lane_mask = DataWidth'(32'h0000_00FF);
                sign_bit  = shifted[7];
            end
            HALF: begin
                lane_mask = DataWidth'(32'h0000_FFFF);
                sign_bit  = shifted[15];
            end
            default: begin
                lane_mask = DataWidth'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
        endcase
        load_data = shifted & lane_mask;
        if (!is_unsigned && sign_bit) begin
            load_data = load_data | ~lane_mask;
        end
        placed_mask = lane_mask << shift;
        merged_word = (merge_word & ~placed_mask)
                    | ((store_data << shift) & placed_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: request handshake to single-port RAM, with RMW sub-word stores.
// Optional LOAD_STORE_UNIT_ALIGN_CHECK_EN: misaligned accesses error instead of rounding down.
module load_store_unit
    import Isa::*;
#(
    parameter  int DataWidth   = MEMORY_DATA_WIDTH,
    parameter  int Depth       = MEMORY_DEPTH,
    localparam int OffsetWidth = $clog2(DataWidth / 8),
    localparam int IndexWidth  = $clog2(Depth),
    localparam int AddrWidth   = IndexWidth + OffsetWidth
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_request_valid,
    output logic                 o_request_ready,
    input  logic                 i_request_write,
    input  logic [1:0]           i_request_size,
    input  logic                 i_request_unsigned,
    input  logic [AddrWidth-1:0] i_request_address,
    input  logic [DataWidth-1:0] i_request_write_data,
    output logic                 o_response_valid,
    input  logic                 i_response_ready,
    output logic [DataWidth-1:0] o_response_read_data,
    output logic                 o_response_error,
    RamPort.Controller           ram_port
);

    lsu_state_t             state_q;
    lsu_state_t             state_d;
    logic                   write_q;
    access_size_t           size_q;
    logic                   unsigned_q;
    logic [OffsetWidth-1:0] offset_q;
    logic [IndexWidth-1:0]  index_q;
    logic [DataWidth-1:0]   store_q;
    logic [DataWidth-1:0]   word_q;
    logic [DataWidth-1:0]   rsp_data_q;
    logic                   rsp_error_q;

    logic [OffsetWidth-1:0] req_offset;
    logic [OffsetWidth-1:0] eff_offset;
    logic [OffsetWidth-1:0] align_mask;
    logic [IndexWidth-1:0]  req_index;
    logic                   req_misaligned;
    logic                   req_error;
    logic                   accept;
    logic                   ram_en;
    logic                   ram_we;
    logic [DataWidth-1:0]   load_data;
    logic [DataWidth-1:0]   merged_word;

    assign req_offset = i_request_address[OffsetWidth-1:0];
    assign req_index  = i_request_address[AddrWidth-1:OffsetWidth];
    assign accept     = i_request_valid && (state_q == IDLE);

    // Classify the offered request: alignment, range and size errors.
    always_comb begin
        align_mask = '0;
        unique case (i_request_size)
            2'd1:    align_mask = OffsetWidth'(1);
            2'd2:    align_mask = OffsetWidth'(3);
            default: align_mask = '0;
        endcase
        req_misaligned = |(req_offset & align_mask);
        req_error = (i_request_size == 2'd3)
                  || (32'(req_index) >= 32'(Depth));
`ifdef LOAD_STORE_UNIT_ALIGN_CHECK_EN
        req_error  = req_error || req_misaligned;
        eff_offset = req_offset;
`else
        eff_offset = req_offset & ~align_mask;
`endif
    end

    // State register; reset drops RAM enables at once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and RAM strobe decode.
    always_comb begin
        state_d = state_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_error) begin
                        state_d = RESPOND;
                    end else if (i_request_write && i_request_size == 2'd2) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                ram_en  = 1'b1;
                state_d = write_q ? WRITE : RESPOND;
            end
            WRITE: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                state_d = RESPOND;
            end
            RESPOND: begin
                if (i_response_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the request on accept; capture the RAM word and load result in READ.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            write_q     <= 1'b0;
            size_q      <= BYTE;
            unsigned_q  <= 1'b0;
            offset_q    <= '0;
            index_q     <= '0;
            store_q     <= '0;
            word_q      <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else if (accept) begin
            write_q     <= i_request_write;
            size_q      <= access_size_t'(i_request_size);
            unsigned_q  <= i_request_unsigned;
            offset_q    <= eff_offset;
            index_q     <= req_index;
            store_q     <= i_request_write_data;
            rsp_data_q  <= '0;
            rsp_error_q <= req_error;
        end else if (state_q == READ) begin
            word_q <= ram_port.read_data;
            if (!write_q) begin
                rsp_data_q <= load_data;
            end
        end
    end

    byte_lane_aligner #(
        .DataWidth   (DataWidth),
        .OffsetWidth (OffsetWidth)
    ) u_aligner (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .offset      (offset_q),
        .load_word   (ram_port.read_data),
        .merge_word  (word_q),
        .store_data  (store_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign o_request_ready      = (state_q == IDLE);
    assign o_response_valid     = (state_q == RESPOND);
    assign o_response_read_data = rsp_data_q;
    assign o_response_error     = rsp_error_q;

    assign ram_port.enable       = ram_en;
    assign ram_port.write_enable = ram_we;
    assign ram_port.address      = index_q;
    assign ram_port.write_data   = merged_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural RAM.
// A second, shallower instance exercises the out-of-range check.
module tb_load_store_unit;
    import Isa::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        s_req_valid;
    logic        s_req_ready;
    logic [9:0]  s_req_addr;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_data;
    logic        s_rsp_err;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    int s_en_cnt = 0;

    logic [31:0] mem [0:255];

    RamPort #(.DataWidth(32), .AddrWidth(8)) ram ();
    RamPort #(.DataWidth(32), .AddrWidth(8)) s_ram ();

    load_store_unit #(.DataWidth(32), .Depth(256)) u_dut (
        .i_clock              (clk),
        .i_reset_n            (rst_n),
        .i_request_valid      (req_valid),
        .o_request_ready      (req_ready),
        .i_request_write      (req_write),
        .i_request_size       (req_size),
        .i_request_unsigned   (req_uns),
        .i_request_address    (req_addr),
        .i_request_write_data (req_wdata),
        .o_response_valid     (rsp_valid),
        .i_response_ready     (rsp_ready),
        .o_response_read_data (rsp_data),
        .o_response_error     (rsp_err),
        .ram_port             (ram)
    );

    load_store_unit #(.DataWidth(32), .Depth(192)) u_small (
        .i_clock              (clk),
        .i_reset_n            (rst_n),
        .i_request_valid      (s_req_valid),
        .o_request_ready      (s_req_ready),
        .i_request_write      (1'b0),
        .i_request_size       (2'd2),
        .i_request_unsigned   (1'b0),
        .i_request_address    (s_req_addr),
        .i_request_write_data (32'h0),
        .o_response_valid     (s_rsp_valid),
        .i_response_ready     (1'b1),
        .o_response_read_data (s_rsp_data),
        .o_response_error     (s_rsp_err),
        .ram_port             (s_ram)
    );

    assign ram.read_data   = mem[ram.address];
    assign s_ram.read_data = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM write port.
    always @(posedge clk) begin
        if (ram.enable && ram.write_enable) mem[ram.address] <= ram.write_data;
    end

    // Count RAM strobe cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram.enable) en_cnt++;
        if (ram.write_enable) we_cnt++;
        if (s_ram.enable) s_en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data,
                         output logic err);
        @(negedge clk);
        req_write = wr;
        req_size  = sz;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        lat  = -1;
        data = 'x;
        err  = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat  = i;
                data = rsp_data;
                err  = rsp_err;
                break;
            end
        end
    endtask

    int          lat;
    int          e0;
    int          w0;
    int          n;
    logic [31:0] d;
    logic        er;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_uns     = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b1;
        s_req_valid = 1'b0;
        s_req_addr  = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_ram_en", 32'(ram.enable), 32'd0);
        rst_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, lat, d, er);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(er), 32'd0);
        check("sw_data", d, 32'h0);
        check("sw_mem", mem[4], 32'hDEADBEEF);

        issue(1'b0, 2'd0, 1'b0, 10'h010, 32'h0, lat, d, er);
        check("lb0_lat", 32'(lat), 32'd2);
        check("lb0", d, 32'hFFFFFFEF);
        issue(1'b0, 2'd0, 1'b0, 10'h011, 32'h0, lat, d, er);
        check("lb1", d, 32'hFFFFFFBE);
        issue(1'b0, 2'd0, 1'b0, 10'h012, 32'h0, lat, d, er);
        check("lb2", d, 32'hFFFFFFAD);
        issue(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, lat, d, er);
        check("lb3", d, 32'hFFFFFFDE);
        issue(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, lat, d, er);
        check("lbu3", d, 32'h000000DE);

        e0 = en_cnt;
        w0 = we_cnt;
        issue(1'b1, 2'd1, 1'b0, 10'h012, 32'hCAFE1234, lat, d, er);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_en_cycles", 32'(en_cnt - e0), 32'd2);
        check("sh_we_cycles", 32'(we_cnt - w0), 32'd1);
        check("sh_mem", mem[4], 32'h1234BEEF);
        issue(1'b0, 2'd1, 1'b1, 10'h012, 32'h0, lat, d, er);
        check("lhu2", d, 32'h00001234);
        issue(1'b0, 2'd1, 1'b0, 10'h010, 32'h0, lat, d, er);
        check("lh0", d, 32'hFFFFBEEF);

        e0 = en_cnt;
        issue(1'b0, 2'd2, 1'b0, 10'h011, 32'h0, lat, d, er);
`ifdef LOAD_STORE_UNIT_ALIGN_CHECK_EN
        check("mis_err", 32'(er), 32'd1);
        check("mis_data", d, 32'h0);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_en_cycles", 32'(en_cnt - e0), 32'd0);
`else
        check("mis_err", 32'(er), 32'd0);
        check("mis_data", d, 32'h1234BEEF);
        check("mis_lat", 32'(lat), 32'd2);
        check("mis_en_cycles", 32'(en_cnt - e0), 32'd1);
`endif

        e0 = en_cnt;
        issue(1'b0, 2'd3, 1'b0, 10'h010, 32'h0, lat, d, er);
        check("rsv_err", 32'(er), 32'd1);
        check("rsv_data", d, 32'h0);
        check("rsv_lat", 32'(lat), 32'd1);
        check("rsv_en_cycles", 32'(en_cnt - e0), 32'd0);

        // Consumer stall with a second request held valid.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_uns   = 1'b0;
        req_addr  = 10'h010;
        req_valid = 1'b1;
        @(negedge clk);
        req_size = 2'd0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", rsp_data, 32'h1234BEEF);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hs_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("acc2_req_ready", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("acc2_data", rsp_data, 32'hFFFFFFEF);

        // Reset during the WRITE cycle of a byte store.
        issue(1'b1, 2'd2, 1'b0, 10'h020, 32'h55667788, lat, d, er);
        check("pre_mem", mem[8], 32'h55667788);
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 10'h020;
        req_wdata = 32'h000000AA;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_in_write", 32'(ram.write_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_en", 32'(ram.enable), 32'd0);
        check("rst_mid_we", 32'(ram.write_enable), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_data", rsp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_mem", mem[8], 32'h55667788);
        issue(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, lat, d, er);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_data", d, 32'h55667788);

        // Out-of-range on the 192-word instance.
        @(negedge clk);
        s_req_addr  = 10'h300;
        s_req_valid = 1'b1;
        e0 = s_en_cnt;
        @(negedge clk);
        s_req_valid = 1'b0;
        check("oor_valid", 32'(s_rsp_valid), 32'd1);
        check("oor_err", 32'(s_rsp_err), 32'd1);
        check("oor_data", s_rsp_data, 32'h0);
        check("oor_en_cycles", 32'(s_en_cnt - e0), 32'd0);
        @(negedge clk);
        s_req_addr  = 10'h2FC;
        s_req_valid = 1'b1;
        @(negedge clk);
        s_req_valid = 1'b0;
        @(negedge clk);
        check("inr_valid", 32'(s_rsp_valid), 32'd1);
        check("inr_err", 32'(s_rsp_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
